load_store_unit: RTL

Initiator side of the data-memory port. Accepts one load/store request at a time from the MIPS execute/memory stage and converts byte addresses to word indices. Performs sub-word stores as read-modify-write on the word-wide memory, and returns sign/zero-extended load data. It sits between the pipeline's memory stage and `data_memory`, and is the only block that drives the memory's address, write data and write enable.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_lane_align.sv | 67 ++++++
 rtl/load_store_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared opcode field positions, size encodings and FSM states for the
// load/store unit.
package lsu_pkg;

  localparam int OP_STORE    = 3;
  localparam int OP_UNSIGNED = 2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  localparam int DEFAULT_MEM_WORDS = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane handling: load extract/extend, sub-word store merge and
// alignment/size checking.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged,
  output logic        bad_align
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Offset 0 is the most significant lane.
  always_comb begin
    lane_b = rdata[7:0];
    case (offset)
      2'd0: lane_b = rdata[31:24];
      2'd1: lane_b = rdata[23:16];
      2'd2: lane_b = rdata[15:8];
      2'd3: lane_b = rdata[7:0];
      default: lane_b = rdata[7:0];
    endcase
    lane_h = offset[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    load_data = 32'h0;
    case (size)
      SIZE_BYTE: load_data = uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SIZE_HALF: load_data = uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      SIZE_WORD: load_data = rdata;
      default:   load_data = 32'h0;
    endcase
  end

  always_comb begin
    merged = wdata;
    if (size == SIZE_BYTE) begin
      case (offset)
        2'd0: merged = {wdata[7:0], rdata[23:0]};
        2'd1: merged = {rdata[31:24], wdata[7:0], rdata[15:0]};
        2'd2: merged = {rdata[31:16], wdata[7:0], rdata[7:0]};
        2'd3: merged = {rdata[31:8], wdata[7:0]};
        default: merged = rdata;
      endcase
    end else if (size == SIZE_HALF) begin
      merged = offset[1] ? {rdata[31:16], wdata[15:0]} : {wdata[15:0], rdata[15:0]};
    end
  end

  always_comb begin
    bad_align = 1'b1;
    case (size)
      SIZE_BYTE: bad_align = 1'b0;
      SIZE_HALF: bad_align = offset[0];
      SIZE_WORD: bad_align = (offset != 2'd0);
      default:   bad_align = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, sub-word stores done as
// read-modify-write, extended load data returned with a one-cycle pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic [31:0] data_to_write,
  output logic        WE_memory,
  input  logic [31:0] data_read
);

  lsu_state_t  state, state_next;
  logic [3:0]  op_q;
  logic [31:0] addr_q, wdata_q, merged_q, rdata_q;
  logic        err_q;

  logic [3:0]  al_op;
  logic [1:0]  al_off;
  logic [31:0] load_data, merged;
  logic        bad_align, out_of_range, req_bad;
  logic        is_store, is_word, we_raw;
  logic [31:0] word_idx;

  // In IDLE the checker looks at the incoming request; afterwards at the latched one.
  assign al_op  = (state == IDLE) ? req_op : op_q;
  assign al_off = (state == IDLE) ? req_addr[1:0] : addr_q[1:0];

  lsu_lane_align u_align (
    .size      (al_op[1:0]),
    .uns       (al_op[OP_UNSIGNED]),
    .offset    (al_off),
    .rdata     (data_read),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged),
    .bad_align (bad_align)
  );

  assign out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
  assign req_bad      = bad_align || out_of_range;
  assign is_store     = op_q[OP_STORE];
  assign is_word      = (op_q[1:0] == SIZE_WORD);
  assign word_idx     = {2'b00, addr_q[31:2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= 4'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= 32'h0;
            err_q   <= req_bad;
          end
        end
        ACCESS: begin
          if (!is_store) rdata_q <= load_data;
          else           merged_q <= merged;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    address       = 32'h0;
    data_to_write = 32'h0;
    we_raw        = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid) state_next = req_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        address = word_idx;
        if (is_store && is_word) begin
          we_raw        = 1'b1;
          data_to_write = wdata_q;
          state_next    = RESP;
        end else if (is_store) begin
          state_next = WRITE;
        end else begin
          state_next = RESP;
        end
      end
      WRITE: begin
        address       = word_idx;
        we_raw        = 1'b1;
        data_to_write = merged_q;
        state_next    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gating by reset keeps a write that is in flight on the reset edge from landing.
  assign WE_memory  = we_raw && !reset;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
